approx_mul_err_monitor: RTL and testbench

//  Downstream stage for signed_int_mul: takes operands A, B and the approximate product R.

---
 rtl/approx_mul_err_monitor.sv | 179 +++++++++++++++++
 tb/tb_approx_mul_err_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor: recomputes the exact signed A*B next to an approximate product R
// and accumulates error statistics. Optional signed bias accumulator: define ERR_MON_BIAS_EN.
module approx_mul_err_monitor #(
  parameter int W     = 8,
  parameter int CNT_W = 32,
  parameter int SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [2*W-1:0]   R,
  input  logic             last,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] err_sum,
  output logic [2*W:0]     max_err,
  output logic [W-1:0]     max_A,
  output logic [W-1:0]     max_B,
  output logic             busy,
  output logic             done,
  output logic             overflow
`ifdef ERR_MON_BIAS_EN
  ,
  output logic signed [SUM_W-1:0] err_bias
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  // Handshake: a sample transfers on a rising edge where in_valid and in_ready are both
  // high and start is low. in_ready is high only in RUN and never depends on in_valid.
  logic accept;

  logic                  s1_valid, s1_last;
  logic [W-1:0]          s1_a, s1_b;
  logic [2*W-1:0]        s1_r;
  logic                  s2_valid, s2_last;
  logic [W-1:0]          s2_a, s2_b;
  logic signed [2*W:0]   s2_diff;

  logic signed [2*W-1:0] op_a, op_b, exact;
  logic signed [2*W:0]   diff;
  logic [2*W:0]          absd;
  logic [SUM_W:0]        sum_ext;
  logic                  cnt_sat, err_sat, is_err, ovf_hit;
`ifdef ERR_MON_BIAS_EN
  logic [SUM_W:0]        bias_ext;
  logic                  bias_ovf;
`endif

  assign in_ready = (state == RUN);
  assign accept   = in_valid & in_ready & ~start;
  assign busy     = (state == RUN) | s1_valid | s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (accept && last) state_nxt = DRAIN;
        DRAIN:   if (!s1_valid && !s2_valid) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  // Stage 2 arithmetic: operands sign-extended to 2W so the truncated product is exact.
  always_comb begin
    op_a  = signed'({{W{s1_a[W-1]}}, s1_a});
    op_b  = signed'({{W{s1_b[W-1]}}, s1_b});
    exact = op_a * op_b;
    diff  = signed'({exact[2*W-1], exact}) - signed'({s1_r[2*W-1], s1_r});
  end

  always_comb begin
    absd    = s2_diff[2*W] ? $unsigned(-s2_diff) : $unsigned(s2_diff);
    is_err  = (absd != '0);
    cnt_sat = &sample_count;
    err_sat = &err_count;
    sum_ext = {1'b0, err_sum} + {{(SUM_W-2*W){1'b0}}, absd};
`ifdef ERR_MON_BIAS_EN
    bias_ext = {err_bias[SUM_W-1], err_bias} + {{(SUM_W-2*W){s2_diff[2*W]}}, s2_diff};
    bias_ovf = bias_ext[SUM_W] ^ bias_ext[SUM_W-1];
    ovf_hit  = s2_valid & (cnt_sat | (is_err & err_sat) | sum_ext[SUM_W] | bias_ovf);
`else
    ovf_hit  = s2_valid & (cnt_sat | (is_err & err_sat) | sum_ext[SUM_W]);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_r     <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_diff  <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid & ~start;
      if (accept) begin
        s1_a    <= A;
        s1_b    <= B;
        s1_r    <= R;
        s1_last <= last;
      end
      if (s1_valid) begin
        s2_a    <= s1_a;
        s2_b    <= s1_b;
        s2_last <= s1_last;
        s2_diff <= diff;
      end
    end
  end

  // Stage 3: saturating accumulation; max keeps the first sample on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count <= '0;
      err_count    <= '0;
      err_sum      <= '0;
      max_err      <= '0;
      max_A        <= '0;
      max_B        <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
`ifdef ERR_MON_BIAS_EN
      err_bias     <= '0;
`endif
    end else if (start) begin
      sample_count <= '0;
      err_count    <= '0;
      err_sum      <= '0;
      max_err      <= '0;
      max_A        <= '0;
      max_B        <= '0;
      done         <= 1'b0;
      overflow     <= 1'b0;
`ifdef ERR_MON_BIAS_EN
      err_bias     <= '0;
`endif
    end else begin
      done <= s2_valid & s2_last;
      if (s2_valid) begin
        if (!cnt_sat) sample_count <= sample_count + CNT_W'(1);
        if (is_err && !err_sat) err_count <= err_count + CNT_W'(1);
        err_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        if (absd > max_err) begin
          max_err <= absd;
          max_A   <= s2_a;
          max_B   <= s2_b;
        end
`ifdef ERR_MON_BIAS_EN
        if (bias_ovf)
          err_bias <= bias_ext[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
        else
          err_bias <= bias_ext[SUM_W-1:0];
`endif
      end
      if (ovf_hit) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Bench for approx_mul_err_monitor: directed and randomised sweeps scored against a
// queue of accepted samples reduced with plain integer arithmetic.
module tb_approx_mul_err_monitor;
  localparam int W     = 8;
  localparam int SUM_W = 48;

  logic clk = 1'b0;
  logic rst, start, in_valid, last;
  logic [W-1:0]   a_in, b_in;
  logic [2*W-1:0] r_in;

  logic           in_ready, busy, done, overflow;
  logic [31:0]    sample_count, err_count;
  logic [SUM_W-1:0] err_sum;
  logic [2*W:0]   max_err;
  logic [W-1:0]   max_a, max_b;

  logic           q_in_ready, q_busy, q_done, q_overflow;
  logic [3:0]     q_sample_count, q_err_count;
  logic [SUM_W-1:0] q_err_sum;
  logic [2*W:0]   q_max_err;
  logic [W-1:0]   q_max_a, q_max_b;

  typedef struct { int a; int b; int r; } sample_t;
  sample_t exp_q[$];
  int checks = 0;
  int errors = 0;

  approx_mul_err_monitor #(.W(W), .CNT_W(32), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .R(r_in), .last(last),
    .sample_count(sample_count), .err_count(err_count), .err_sum(err_sum),
    .max_err(max_err), .max_A(max_a), .max_B(max_b),
    .busy(busy), .done(done), .overflow(overflow)
  );

  approx_mul_err_monitor #(.W(W), .CNT_W(4), .SUM_W(SUM_W)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(q_in_ready),
    .A(a_in), .B(b_in), .R(r_in), .last(last),
    .sample_count(q_sample_count), .err_count(q_err_count), .err_sum(q_err_sum),
    .max_err(q_max_err), .max_A(q_max_a), .max_B(q_max_b),
    .busy(q_busy), .done(q_done), .overflow(q_overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input int a, input int b, input int r, input bit l);
    a_in = a[W-1:0];
    b_in = b[W-1:0];
    r_in = r[2*W-1:0];
    last = l;
    in_valid = 1'b1;
    exp_q.push_back('{a, b, int'($signed(r_in))});
    step();
    in_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      step();
    end
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_ready_after"}, in_ready, 0);
  endtask

  function automatic longint sat(input longint v, input int bits);
    longint lim;
    lim = (longint'(1) << bits) - 1;
    return (v > lim) ? lim : v;
  endfunction

  // scoreboard: reduce the accepted-sample queue to the expected statistics
  task automatic expect_stats(input string tag);
    longint n, ne, sum, mx, d;
    int ma, mb;
    n = exp_q.size(); ne = 0; sum = 0; mx = 0; ma = 0; mb = 0;
    foreach (exp_q[i]) begin
      d = longint'(exp_q[i].a) * longint'(exp_q[i].b) - longint'(exp_q[i].r);
      if (d < 0) d = -d;
      if (d != 0) ne++;
      sum += d;
      if (d > mx) begin
        mx = d; ma = exp_q[i].a; mb = exp_q[i].b;
      end
    end
    chk({tag, "_sample_count"}, sample_count, sat(n, 32));
    chk({tag, "_err_count"}, err_count, sat(ne, 32));
    chk({tag, "_err_sum"}, err_sum, sum);
    chk({tag, "_max_err"}, max_err, mx);
    chk({tag, "_max_A"}, $signed(max_a), ma);
    chk({tag, "_max_B"}, $signed(max_b), mb);
    chk({tag, "_overflow"}, overflow, (n > sat(n, 32)) || (ne > sat(ne, 32)));
    chk({tag, "_c4_sample_count"}, q_sample_count, sat(n, 4));
    chk({tag, "_c4_err_count"}, q_err_count, sat(ne, 4));
    chk({tag, "_c4_overflow"}, q_overflow, (n > 15) || (ne > 15));
  endtask

  initial begin
    int a, b, r, ex, mode;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; last = 1'b0;
    a_in = '0; b_in = '0; r_in = '0;
    step(); step();
    chk("rst_sample_count", sample_count, 0);
    chk("rst_err_sum", err_sum, 0);
    chk("rst_max_err", max_err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", in_ready, 0);

    // exact product: no error, one done pulse
    do_start();
    chk("t1_ready", in_ready, 1);
    send(3, 5, 15, 1'b1);
    wait_done("t1");
    expect_stats("t1");

    // most negative operands
    do_start();
    send(-128, -128, 16000, 1'b1);
    wait_done("t2");
    expect_stats("t2");
    chk("t2_err_sum_const", err_sum, 384);
    chk("t2_max_A_const", $signed(max_a), -128);

    // tie on max error keeps the first sample
    do_start();
    send(10, 10, 90, 1'b0);
    send(5, 4, 10, 1'b1);
    wait_done("t3");
    expect_stats("t3");
    chk("t3_max_A_const", $signed(max_a), 10);
    chk("t3_err_sum_const", err_sum, 20);

    // counter saturation on the 4-bit instance
    do_start();
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      send(a, b, a * b + 1, i == 19);
    end
    wait_done("t4");
    expect_stats("t4");
    chk("t4_c4_count_const", q_err_count, 15);
    chk("t4_c4_overflow_const", q_overflow, 1);

    // restart drops in-flight samples
    do_start();
    send(1, 2, 7, 1'b0);
    send(3, 3, 0, 1'b0);
    do_start();
    chk("t5_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) step();
    chk("t5_sample_count", sample_count, 0);
    chk("t5_err_sum", err_sum, 0);
    // start together with in_valid: start wins
    a_in = 8'd9; b_in = 8'd9; r_in = '0; in_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    send(2, 2, 4, 1'b1);
    wait_done("t5b");
    expect_stats("t5b");

    // randomised sweep of A with random B, approximation error styles and idle gaps
    do_start();
    for (int i = -128; i <= 126; i++) begin
      b = int'($urandom_range(0, 255)) - 128;
      ex = i * b;
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: r = ex;
        1: r = ex + int'($urandom_range(0, 64)) - 32;
        2: r = int'($urandom_range(0, 65535)) - 32768;
        default: r = ex ^ int'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 3) == 0) step();
      send(i, b, r, i == 126);
    end
    wait_done("t6");
    expect_stats("t6");

    // reset mid-sweep clears immediately, no done pulse follows
    do_start();
    send(7, 7, 0, 1'b0);
    send(-5, 9, 3, 1'b0);
    step();
    rst = 1'b1;
    #2;
    chk("t7_async_count", sample_count, 0);
    chk("t7_async_err_sum", err_sum, 0);
    chk("t7_async_ready", in_ready, 0);
    step();
    rst = 1'b0;
    exp_q.delete();
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
        if (done) pulses++;
        step();
      end
      chk("t7_no_done", pulses, 0);
    end
    expect_stats("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
